// File: rtl/rgb_top.sv
`default_nettype none
// ============================================================================
// Module      : rgb_top
// Description : RGB LED controller. A push button steps a 3-bit colour index
//               through a fixed 8-colour sequence; the selected colour drives
//               the red/green/blue pins, gated by a free-running PWM dimmer.
//
// Ports       : clk    - system clock, rising edge
//               reset  - asynchronous, active-low reset
//               button - raw push button (asynchronous to clk, active-high)
//               red    - red LED drive, active-high, registered
//               green  - green LED drive, active-high, registered
//               blue   - blue LED drive, active-high, registered
//
// Parameters  : PWM_BITS        - PWM counter width (period 2**PWM_BITS)
//               DUTY            - PWM on-count; >= 2**PWM_BITS is always on,
//                                 0 is always off
//               DEBOUNCE_CYCLES - stable-sample count for the debounce stage
//
// Options     : RGB_DEBOUNCE_EN - when defined, a debounce stage sits between
//                                 the synchronizer and the edge detector
//
// Revision    : 1.0 - initial release
// ============================================================================
module rgb_top #(
    parameter int PWM_BITS        = 4,
    parameter int DUTY            = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic button,
    output logic red,
    output logic green,
    output logic blue
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------------
    generate
        if (PWM_BITS < 1) begin : g_bad_pwm_bits
            $error("rgb_top: PWM_BITS must be >= 1");
        end
        if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
            $error("rgb_top: DEBOUNCE_CYCLES must be >= 1");
        end
        if (DUTY < 0) begin : g_bad_duty
            $error("rgb_top: DUTY must be >= 0");
        end
    endgenerate

    // A duty at or above the period cannot be represented in the counter
    // width, so it is handled by a separate always-on flag.
    localparam logic                c_pwm_full = (DUTY >= (2 ** PWM_BITS));
    localparam logic [PWM_BITS-1:0] c_duty     = PWM_BITS'(DUTY);

    // ------------------------------------------------------------------------
    // Button synchronizer (s1, s2)
    // ------------------------------------------------------------------------
    logic r_s1;
    logic r_s2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= button;
            r_s2 <= r_s1;
        end
    end

    // ------------------------------------------------------------------------
    // Optional debounce: the stable level follows s2 only after s2 has
    // disagreed with it for DEBOUNCE_CYCLES consecutive samples.
    // ------------------------------------------------------------------------
    logic w_edge_src;

`ifdef RGB_DEBOUNCE_EN
    localparam int               c_db_w    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_db_w-1:0] c_db_last = c_db_w'(DEBOUNCE_CYCLES - 1);

    logic              r_stable;
    logic [c_db_w-1:0] r_db_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stable <= 1'b0;
            r_db_cnt <= '0;
        end else if (r_s2 == r_stable) begin
            r_db_cnt <= '0;
        end else if (r_db_cnt == c_db_last) begin
            // This is the DEBOUNCE_CYCLES-th consecutive differing sample.
            r_stable <= r_s2;
            r_db_cnt <= '0;
        end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
        end
    end

    assign w_edge_src = r_stable;
`else
    assign w_edge_src = r_s2;
`endif

    // ------------------------------------------------------------------------
    // Rising-edge detector: one press per button edge however long it is held
    // ------------------------------------------------------------------------
    logic r_s3;
    logic w_press;

    assign w_press = w_edge_src & ~r_s3;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s3 <= 1'b0;
        end else begin
            r_s3 <= w_edge_src;
        end
    end

    // ------------------------------------------------------------------------
    // Colour index, wraps 7 -> 0 through natural 3-bit overflow
    // ------------------------------------------------------------------------
    logic [2:0] r_index;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_index <= 3'd0;
        end else if (w_press) begin
            r_index <= r_index + 3'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Colour map, index -> {red, green, blue}
    // ------------------------------------------------------------------------
    logic [2:0] w_colour;

    always_comb begin
        w_colour = 3'b000;
        case (r_index)
            3'd0:    w_colour = 3'b000;
            3'd1:    w_colour = 3'b100;
            3'd2:    w_colour = 3'b010;
            3'd3:    w_colour = 3'b001;
            3'd4:    w_colour = 3'b110;
            3'd5:    w_colour = 3'b011;
            3'd6:    w_colour = 3'b101;
            3'd7:    w_colour = 3'b111;
            default: w_colour = 3'b000;
        endcase
    end

    // ------------------------------------------------------------------------
    // Free-running PWM dimmer
    // ------------------------------------------------------------------------
    logic [PWM_BITS-1:0] r_cnt;
    logic                w_pwm_on;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_pwm_on = c_pwm_full | (r_cnt < c_duty);

    // ------------------------------------------------------------------------
    // Registered LED drive
    // ------------------------------------------------------------------------
    logic [2:0] r_rgb;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rgb <= 3'b000;
        end else begin
            r_rgb <= w_colour & {3{w_pwm_on}};
        end
    end

    assign red   = r_rgb[2];
    assign green = r_rgb[1];
    assign blue  = r_rgb[0];

endmodule
`default_nettype wire

// File: tb/tb_rgb_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_rgb_top
// Description : Scoreboard bench for rgb_top. Three instances share button and
//               reset: default duty (8/16), full duty (16) and zero duty (0).
//               The driver pushes the expected pin values for every clock
//               edge; a monitor pops and compares one entry per edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rgb_top;

    logic clk    = 1'b0;
    logic reset  = 1'b0;
    logic button = 1'b0;

    logic red,   green,   blue;
    logic red_f, green_f, blue_f;
    logic red_z, green_z, blue_z;

    always #5 clk = ~clk;

    rgb_top u_dut (
        .clk    (clk),
        .reset  (reset),
        .button (button),
        .red    (red),
        .green  (green),
        .blue   (blue)
    );

    rgb_top #(.PWM_BITS(4), .DUTY(16)) u_full (
        .clk    (clk),
        .reset  (reset),
        .button (button),
        .red    (red_f),
        .green  (green_f),
        .blue   (blue_f)
    );

    rgb_top #(.PWM_BITS(4), .DUTY(0)) u_zero (
        .clk    (clk),
        .reset  (reset),
        .button (button),
        .red    (red_z),
        .green  (green_z),
        .blue   (blue_z)
    );

    typedef struct packed {
        logic [2:0] main;
        logic [2:0] full;
        logic [2:0] zero;
    } exp_t;

    exp_t sb[$];
    exp_t mon_x;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic driving  = 1'b0;

    // Bench-side expectation state
    int         edge_n    = 0;
    logic [2:0] idx_m     = 3'd0;
    logic [1:0] pd        = 2'b00;
    logic       prev_b    = 1'b0;
    logic [2:0] last_main = 3'b000;

    // Colour table written out from the colour list, {red, green, blue}
    function automatic logic [2:0] cmap(input logic [2:0] i);
        logic [2:0] c;
        c = 3'b000;
        case (i)
            3'd1: c = 3'b100;
            3'd2: c = 3'b010;
            3'd3: c = 3'b001;
            3'd4: c = 3'b110;
            3'd5: c = 3'b011;
            3'd6: c = 3'b101;
            3'd7: c = 3'b111;
            default: c = 3'b000;
        endcase
        return c;
    endfunction

    task automatic check3(input string name, input logic [2:0] act, input logic [2:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got rgb=%b, expected rgb=%b at t=%0t", name, act, req, $time);
        end
    endtask

    // One clock of stimulus: set pins on the falling edge and push the pin
    // values expected right after the following rising edge.
    task automatic drive_cycle(input logic b, input logic rn);
        logic np;
        logic pwm;
        exp_t x;
        @(negedge clk);
        driving = 1'b1;
        button  = b;
        reset   = rn;
        if (!rn) begin
            idx_m  = 3'd0;
            pd     = 2'b00;
            prev_b = 1'b0;
            edge_n = 0;
            x      = '0;
        end else begin
            np     = b & ~prev_b;
            prev_b = b;
            // Counter value before edge n is n mod 16; on while below 8.
            pwm    = ((edge_n % 16) < 8);
            x.main = cmap(idx_m) & {3{pwm}};
            x.full = cmap(idx_m);
            x.zero = 3'b000;
            // A press sampled at edge k changes the index at edge k+2, so the
            // pins show it from edge k+3.
            if (pd[1]) idx_m = idx_m + 3'd1;
            pd     = {pd[0], np};
            edge_n = edge_n + 1;
        end
        last_main = x.main;
        sb.push_back(x);
    endtask

    // Monitor: one expected entry per rising edge while stimulus is active
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (driving) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL scoreboard_empty: got no entry, expected one at t=%0t", $time);
                end else begin
                    mon_x = sb.pop_front();
                    check3("main_duty8",  {red,   green,   blue},   mon_x.main);
                    check3("full_duty16", {red_f, green_f, blue_f}, mon_x.full);
                    check3("zero_duty0",  {red_z, green_z, blue_z}, mon_x.zero);
                end
            end
        end
    end

    initial begin
        int k;

        // Reset held low: all pins low
        repeat (4) drive_cycle(1'b0, 1'b0);

        // Release, then a single 1-cycle pulse: red at half duty
        repeat (2) drive_cycle(1'b0, 1'b1);
        drive_cycle(1'b1, 1'b1);
        repeat (100) drive_cycle(1'b0, 1'b1);

        // Eight separated presses: index 1 -> 2..7 -> 0 -> 1
        for (int p = 0; p < 8; p++) begin
            drive_cycle(1'b1, 1'b1);
            repeat (20) drive_cycle(1'b0, 1'b1);
        end

        // Held for 50 cycles: exactly one increment (index 2, green)
        repeat (50) drive_cycle(1'b1, 1'b1);
        repeat (30) drive_cycle(1'b0, 1'b1);

        // Press to index 3 (blue), then reset while the PWM is high
        drive_cycle(1'b1, 1'b1);
        k = 0;
        do begin
            drive_cycle(1'b0, 1'b1);
            k++;
        end while ((last_main != 3'b001) && (k < 40));
        n_checks++;
        if (last_main != 3'b001) begin
            n_fail++;
            $display("FAIL blue_pwm_high_wait: got rgb=%b, expected rgb=001 within 40 cycles", last_main);
        end

        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check3("async_reset_main", {red,   green,   blue},   3'b000);
        check3("async_reset_full", {red_f, green_f, blue_f}, 3'b000);
        check3("async_reset_zero", {red_z, green_z, blue_z}, 3'b000);

        repeat (3) drive_cycle(1'b0, 1'b0);

        // After release the index is 0: dark, then one press gives red
        repeat (40) drive_cycle(1'b0, 1'b1);
        drive_cycle(1'b1, 1'b1);
        repeat (20) drive_cycle(1'b0, 1'b1);

        @(posedge clk);
        #2;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
